// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared pointer/count helpers for the programmable-threshold FIFO
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

  // Wraps explicitly at entries-1, so depths that are not a power of two work.
  function automatic int ptr_next(input int ptr, input int entries);
    return (ptr == entries - 1) ? 0 : ptr + 1;
  endfunction

  function automatic int cnt_width(input int entries);
    return $clog2(entries + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ptr.sv
// ============================================================================
// fifo_ptr : wrap-around pointer register with increment and clear controls
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int PW      = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (clr) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= PW'(ptr_next(32'(r_ptr), ENTRIES));
    end
  end

  assign ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/fifo_prog.sv
// ============================================================================
// fifo_prog : FWFT FIFO with programmable almost-full/empty and sticky errors
// Revision  : 1.0
// ============================================================================
`default_nettype none

module fifo_prog
  import fifo_pkg::*;
#(
  parameter  int BUSW    = 32,
  parameter  int ENTRIES = 32,
  localparam int CW      = $clog2(ENTRIES + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [BUSW-1:0] datain,
  input  logic            pull,
  output logic [BUSW-1:0] dataout,
  input  logic            flush,
  input  logic [CW-1:0]   afull_thr,
  input  logic [CW-1:0]   aempty_thr,
  output logic            full,
  output logic            empty,
  output logic            almost_full,
  output logic            almost_empty,
  output logic [CW-1:0]   count,
  output logic            overflow,
  output logic            underflow,
  input  logic            clr_err
);

  localparam int           c_PW      = $clog2(ENTRIES);
  localparam int           c_CNTW    = cnt_width(ENTRIES);
  localparam logic [CW-1:0] c_ENTRIES = CW'(ENTRIES);

  logic [BUSW-1:0]   r_mem [ENTRIES];
  logic [c_CNTW-1:0] r_count;
  logic              r_overflow;
  logic              r_underflow;
  logic [c_PW-1:0]   w_head;
  logic [c_PW-1:0]   w_tail;
  logic              w_full;
  logic              w_empty;
  logic              w_pull_ok;
  logic              w_push_ok;
  logic              w_wr;
  logic              w_rd;

  assign w_full    = (r_count == c_ENTRIES);
  assign w_empty   = (r_count == '0);
  assign w_pull_ok = pull & ~w_empty;
  assign w_push_ok = push & (~w_full | w_pull_ok);
  assign w_wr      = w_push_ok & ~flush;
  assign w_rd      = w_pull_ok & ~flush;

  fifo_ptr #(.ENTRIES(ENTRIES), .PW(c_PW)) u_head (
    .clk (clk),
    .rst (rst),
    .inc (w_wr),
    .clr (flush),
    .ptr (w_head)
  );

  fifo_ptr #(.ENTRIES(ENTRIES), .PW(c_PW)) u_tail (
    .clk (clk),
    .rst (rst),
    .inc (w_rd),
    .clr (flush),
    .ptr (w_tail)
  );

  // Storage is deliberately not reset; a write coinciding with rst is dropped.
  always_ff @(posedge clk) begin
    if (w_wr && !rst) begin
      r_mem[w_head] <= datain;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_wr && !w_rd) begin
      r_count <= r_count + 1'b1;
    end else if (w_rd && !w_wr) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Setting wins over clr_err in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (push && !w_push_ok && !flush) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
      if (pull && w_empty && !flush) begin
        r_underflow <= 1'b1;
      end else if (clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign dataout      = w_empty ? '0 : r_mem[w_tail];
  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = r_count;
  assign almost_full  = (afull_thr == '0) | (r_count >= afull_thr);
  assign almost_empty = (aempty_thr >= c_ENTRIES) | (r_count <= aempty_thr);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_fifo_prog.sv
// ============================================================================
// tb_fifo_prog : directed and randomized checks of fifo_prog against a queue model
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_prog;

  localparam int BUSW    = 8;
  localparam int ENTRIES = 5;
  localparam int CW      = $clog2(ENTRIES + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            push = 1'b0;
  logic [BUSW-1:0] datain = '0;
  logic            pull = 1'b0;
  logic [BUSW-1:0] dataout;
  logic            flush = 1'b0;
  logic [CW-1:0]   afull_thr = CW'(4);
  logic [CW-1:0]   aempty_thr = CW'(1);
  logic            full;
  logic            empty;
  logic            almost_full;
  logic            almost_empty;
  logic [CW-1:0]   count;
  logic            overflow;
  logic            underflow;
  logic            clr_err = 1'b0;

  int tests = 0;
  int fails = 0;

  // Reference model: contents as a queue plus two sticky bits.
  logic [BUSW-1:0] mq[$];
  logic            m_ovf = 1'b0;
  logic            m_udf = 1'b0;

  fifo_prog #(.BUSW(BUSW), .ENTRIES(ENTRIES)) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .datain       (datain),
    .pull         (pull),
    .dataout      (dataout),
    .flush        (flush),
    .afull_thr    (afull_thr),
    .aempty_thr   (aempty_thr),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  task automatic model_step(input logic p, input logic [BUSW-1:0] d, input logic pl,
                            input logic f, input logic c);
    bit pull_ok;
    bit push_ok;
    pull_ok = pl && (mq.size() > 0);
    push_ok = p && ((mq.size() < ENTRIES) || pull_ok);
    if (!f && p && !push_ok) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    if (!f && pl && mq.size() == 0) m_udf = 1'b1;
    else if (c) m_udf = 1'b0;
    if (f) begin
      mq.delete();
    end else begin
      if (pull_ok) void'(mq.pop_front());
      if (push_ok) mq.push_back(d);
    end
  endtask

  // One clock with the given inputs; returns 1 ns after the edge with inputs idle.
  task automatic cycle(input logic p, input logic [BUSW-1:0] d, input logic pl,
                       input logic f, input logic c);
    @(negedge clk);
    push = p; datain = d; pull = pl; flush = f; clr_err = c;
    @(posedge clk);
    model_step(p, d, pl, f, c);
    #1;
    push = 1'b0; pull = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    afull_thr = CW'(0);
    #1;
    tests++;
    if (count !== CW'(0) || empty !== 1'b1 || full !== 1'b0 || dataout !== 8'h00 ||
        almost_empty !== 1'b1 || almost_full !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_thr0: count=%0d empty=%b full=%b dout=%h ae=%b af=%b ovf=%b udf=%b, want 0 1 0 00 1 1 0 0",
               count, empty, full, dataout, almost_empty, almost_full, overflow, underflow);
    end
    afull_thr = CW'(4);
    #1;
    tests++;
    if (almost_full !== 1'b0) begin
      fails++;
      $display("FAIL reset_af_thr4: almost_full=%b want 0", almost_full);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill();
    logic [7:0] v;
    for (int i = 0; i < ENTRIES; i++) begin
      v = 8'(8'h11 * (i + 1));
      cycle(1'b1, v, 1'b0, 1'b0, 1'b0);
      tests++;
      if (count !== CW'(i + 1) || almost_full !== (i + 1 >= 4)) begin
        fails++;
        $display("FAIL fill_%0d: count=%0d af=%b, want %0d %b", i, count, almost_full, i + 1, (i + 1 >= 4));
      end
    end
    tests++;
    if (full !== 1'b1 || dataout !== 8'h11 || count !== CW'(5)) begin
      fails++;
      $display("FAIL fill_full: full=%b dout=%h count=%0d, want 1 11 5", full, dataout, count);
    end
  endtask

  task automatic test_full_pushpull();
    logic [7:0] exp;
    cycle(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
    tests++;
    if (count !== CW'(5) || overflow !== 1'b0 || full !== 1'b1) begin
      fails++;
      $display("FAIL full_pushpull: count=%0d ovf=%b full=%b, want 5 0 1", count, overflow, full);
    end
    for (int i = 0; i < ENTRIES; i++) begin
      exp = 8'(8'h22 + 8'h11 * i);
      tests++;
      if (dataout !== exp) begin
        fails++;
        $display("FAIL drain_%0d: dataout=%h want %h", i, dataout, exp);
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    tests++;
    if (empty !== 1'b1 || dataout !== 8'h00 || underflow !== 1'b0) begin
      fails++;
      $display("FAIL drain_empty: empty=%b dout=%h udf=%b, want 1 00 0", empty, dataout, underflow);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < ENTRIES; i++) cycle(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    tests++;
    if (overflow !== 1'b1 || count !== CW'(5) || dataout !== 8'hB0) begin
      fails++;
      $display("FAIL ovf_set: ovf=%b count=%0d dout=%h, want 1 5 b0", overflow, count, dataout);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_sticky: ovf=%b want 1", overflow);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clr: ovf=%b want 0", overflow);
    end
    cycle(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1);
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set_prio: ovf=%b want 1", overflow);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_empty_pushpull();
    cycle(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    tests++;
    if (count !== CW'(1) || dataout !== 8'hA5 || underflow !== 1'b1 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL empty_pushpull: count=%0d dout=%h udf=%b ovf=%b, want 1 a5 1 0",
               count, dataout, underflow, overflow);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    cycle(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    tests++;
    if (count !== CW'(3)) begin
      fails++;
      $display("FAIL flush_pre: count=%0d want 3", count);
    end
    cycle(1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
    tests++;
    if (count !== CW'(0) || empty !== 1'b1 || dataout !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
      fails++;
      $display("FAIL flush_push: count=%0d empty=%b dout=%h ovf=%b udf=%b, want 0 1 00 0 0",
               count, empty, dataout, overflow, underflow);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    tests++;
    if (underflow !== 1'b0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL flush_pull_empty: udf=%b empty=%b, want 0 1", underflow, empty);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    tests++;
    if (count !== CW'(4) || underflow !== 1'b1) begin
      fails++;
      $display("FAIL arst_pre: count=%0d udf=%b, want 4 1", count, underflow);
    end
    #2;
    rst = 1'b1;
    #1;
    mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    tests++;
    if (count !== CW'(0) || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 ||
        dataout !== 8'h00 || almost_empty !== 1'b1) begin
      fails++;
      $display("FAIL arst_immediate: count=%0d empty=%b ovf=%b udf=%b dout=%h ae=%b, want 0 1 0 0 00 1",
               count, empty, overflow, underflow, dataout, almost_empty);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic            p, pl, f, c;
    logic [BUSW-1:0] d;
    int              sz;
    for (int n = 0; n < 400; n++) begin
      p  = ($urandom_range(0, 99) < 55);
      pl = ($urandom_range(0, 99) < 45);
      f  = ($urandom_range(0, 99) < 3);
      c  = ($urandom_range(0, 99) < 8);
      d  = 8'($urandom);
      cycle(p, d, pl, f, c);
      afull_thr  = CW'($urandom_range(0, ENTRIES + 1));
      aempty_thr = CW'($urandom_range(0, ENTRIES + 1));
      #1;
      sz = mq.size();
      tests++;
      if (count !== CW'(sz) || empty !== (sz == 0) || full !== (sz == ENTRIES) ||
          dataout !== ((sz > 0) ? mq[0] : 8'h00) ||
          almost_full !== ((afull_thr == 0) || (sz >= afull_thr)) ||
          almost_empty !== ((aempty_thr >= ENTRIES) || (sz <= aempty_thr)) ||
          overflow !== m_ovf || underflow !== m_udf) begin
        fails++;
        $display("FAIL random_%0d: count=%0d dout=%h f/e=%b%b af/ae=%b%b ovf/udf=%b%b, want %0d %h %b%b %b%b %b%b",
                 n, count, dataout, full, empty, almost_full, almost_empty, overflow, underflow,
                 sz, (sz > 0) ? mq[0] : 8'h00, (sz == ENTRIES), (sz == 0),
                 ((afull_thr == 0) || (sz >= afull_thr)), ((aempty_thr >= ENTRIES) || (sz <= aempty_thr)),
                 m_ovf, m_udf);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_fill();
    test_full_pushpull();
    test_overflow();
    test_empty_pushpull();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_prog.md
FIFO_PROG -- requirements
Module: fifo_prog

Interface
REQ-001 SHALL have parameter BUSW, default 32, data width in bits (>=1).
REQ-002 SHALL have parameter ENTRIES, default 32, storage depth (>=2, any integer, power of two not required).
REQ-003 SHALL have localparam CW = $clog2(ENTRIES+1), the width of the count and threshold ports.
REQ-004 SHALL use one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-005 SHALL have ports, name direction width meaning:
- clk  in  1  clock, rising edge
- rst  in  1  async active-high reset
- push  in  1  write request
- datain  in  BUSW  write data
- pull  in  1  read request (pop)
- dataout  out  BUSW  head-of-queue data, first-word-fall-through
- flush  in  1  synchronous discard of all contents
- afull_thr  in  CW  almost-full threshold
- aempty_thr  in  CW  almost-empty threshold
- full  out  1  count==ENTRIES
- empty  out  1  count==0
- almost_full  out  1  count>=afull_thr
- almost_empty  out  1  count<=aempty_thr
- count  out  CW  entries currently stored
- overflow  out  1  sticky: push refused
- underflow  out  1  sticky: pull on empty
- clr_err  in  1  clears sticky flags

Function
REQ-006 SHALL store data unmodified; dataout SHALL equal the oldest entry combinationally while !empty and SHALL be 0 while empty.
REQ-007 SHALL define pull_ok = pull & !empty and push_ok = push & (!full | pull_ok).
REQ-008 SHALL, on push_ok, write datain at head pointer and advance head at the next rising clk edge.
REQ-009 SHALL, on pull_ok, advance tail at the next rising clk edge; zero-cycle latency from pull to the next word appearing on dataout after that edge.
REQ-010 SHALL update count by +1 on push_ok only, -1 on pull_ok only, and leave it unchanged on both or neither.
REQ-011 SHALL, when full, accept simultaneous push and pull: the freed slot is written, count stays ENTRIES, no overflow.
REQ-012 SHALL, when empty, ignore a simultaneous pull (underflow set), accept the push; count becomes 1.
REQ-013 SHALL wrap head and tail from ENTRIES-1 to 0; no other modulo behaviour, since ENTRIES need not be a power of two.
REQ-014 SHALL, on flush, set head, tail and count to 0 at the next edge; flush SHALL override push and pull in that cycle, and the sticky flags SHALL NOT be set by that cycle's push/pull.
REQ-015 SHALL set overflow on push & !push_ok & !flush, and set underflow on pull & empty & !flush; both SHALL hold until clr_err or rst.
REQ-016 SHALL give set priority over clr_err when both occur in the same cycle.
REQ-017 SHALL derive full, empty, almost_full and almost_empty combinationally from registered count.
REQ-018 SHALL force almost_full=1 when afull_thr==0, and almost_empty=1 when aempty_thr>=ENTRIES.

Reset
REQ-019 SHALL, on rst asserted, immediately clear head, tail, count, overflow and underflow; outputs SHALL be empty=1, full=0, count=0, dataout=0, almost_empty=1, and almost_full=(afull_thr==0).
REQ-020 SHALL NOT reset storage contents.
REQ-021 SHALL discard, on rst asserted mid-operation, any push/pull in that cycle.

Structure
REQ-022 SHALL take from shared package fifo_pkg: function ptr_next(ptr, entries) and function cnt_width(entries).
REQ-023 SHALL instantiate sub-module fifo_ptr (wrap-around pointer register with inc/clear inputs) twice, for head and tail.
REQ-024 SHALL use a flop array for storage; no inferred RAM read latency.

Verification (BUSW=8, ENTRIES=5, afull_thr=4, aempty_thr=1)
REQ-025 SHALL verify: push 0x11..0x55 on 5 cycles -> count=5, full=1, almost_full=1 from count 4; dataout=0x11.
REQ-026 SHALL verify: when full, push 0x66 with pull together -> count stays 5, overflow=0; the pops that follow return 0x22,0x33,0x44,0x55,0x66 (wrap exercised).
REQ-027 SHALL verify: when full, push alone -> overflow=1 and persists; clr_err pulse -> overflow=0; clr_err together with a refused push -> overflow stays 1.
REQ-028 SHALL verify: when empty, push 0xA5 with pull together -> count=1, dataout=0xA5, underflow=1.
REQ-029 SHALL verify: with 3 entries, flush together with push -> next cycle count=0, empty=1, dataout=0, no flag change.
REQ-030 SHALL verify: assert rst asynchronously between edges with 4 entries -> count=0, empty=1, flags=0 immediately, before next clk.
